// File: rtl/rgb_fade_seq.sv
`default_nettype none
// ============================================================================
// Module      : rgb_fade_seq
// Description : Steps an RGB level triple through a fixed 6-colour palette
//               (fade, hold, advance) with a valid/ready handshake to a PWM
//               stage. Optional macro RGB_FADE_GAMMA_EN squares the duty.
// Revision    : 1.0  initial release
// ============================================================================
module rgb_fade_seq #(
  parameter int STEP_DIV   = 12000,
  parameter int HOLD_STEPS = 64
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       ien,
  input  logic       iready,
  output logic       ovalid,
  output logic [7:0] ovduty_r,
  output logic [7:0] ovduty_g,
  output logic [7:0] ovduty_b,
  output logic [2:0] ovidx
);

  localparam int c_cnt_w  = $clog2(STEP_DIV);
  localparam int c_hold_w = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_max   = c_cnt_w'(STEP_DIV - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_STEPS - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_fade = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [7:0]          r_lvl_r, r_lvl_g, r_lvl_b;
  logic [2:0]          r_idx;
  logic                r_valid;

  logic [23:0] w_tgt;
  logic [7:0]  w_nxt_r, w_nxt_g, w_nxt_b;
  logic        w_run, w_tick_due, w_tick;
  logic        w_fade_tick, w_hold_tick, w_hold_done;
  logic        w_at_tgt, w_changed;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = {8'd255, 8'd0,   8'd0  };
      3'd1:    palette = {8'd255, 8'd255, 8'd0  };
      3'd2:    palette = {8'd0,   8'd255, 8'd0  };
      3'd3:    palette = {8'd0,   8'd255, 8'd255};
      3'd4:    palette = {8'd0,   8'd0,   8'd255};
      3'd5:    palette = {8'd255, 8'd0,   8'd255};
      default: palette = 24'd0;
    endcase
  endfunction

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      step_toward = cur + 8'd1;
    else if (cur > tgt) step_toward = cur - 8'd1;
    else                step_toward = cur;
  endfunction

  assign w_tgt = palette(r_idx);

  // Tick decode: a tick that would overwrite a pending duty set is held back,
  // freezing the prescaler at its last count until the handshake has cleared.
  always_comb begin
    w_run       = ien && (r_state != c_st_idle);
    w_tick_due  = (r_cnt == c_cnt_max);
    w_tick      = w_run && w_tick_due && !r_valid;
    w_fade_tick = w_tick && (r_state == c_st_fade);
    w_hold_tick = w_tick && (r_state == c_st_hold);
    w_hold_done = w_hold_tick && (r_hold_cnt == c_hold_last);
    w_nxt_r     = step_toward(r_lvl_r, w_tgt[23:16]);
    w_nxt_g     = step_toward(r_lvl_g, w_tgt[15:8]);
    w_nxt_b     = step_toward(r_lvl_b, w_tgt[7:0]);
    w_at_tgt    = (w_nxt_r == w_tgt[23:16]) && (w_nxt_g == w_tgt[15:8]) &&
                  (w_nxt_b == w_tgt[7:0]);
    w_changed   = (w_nxt_r != r_lvl_r) || (w_nxt_g != r_lvl_g) || (w_nxt_b != r_lvl_b);
  end

  always_ff @(posedge iclk) begin
    if (irst) r_state <= c_st_idle;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (ien) w_state_nxt = c_st_fade;
      c_st_fade: if (w_fade_tick && w_at_tgt) w_state_nxt = c_st_hold;
      c_st_hold: if (w_hold_done) w_state_nxt = c_st_fade;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_cnt      <= '0;
      r_hold_cnt <= '0;
      r_lvl_r    <= 8'd0;
      r_lvl_g    <= 8'd0;
      r_lvl_b    <= 8'd0;
      r_idx      <= 3'd0;
      r_valid    <= 1'b0;
    end else begin
      if (w_run && !(w_tick_due && r_valid))
        r_cnt <= w_tick_due ? '0 : r_cnt + c_cnt_w'(1);
      if (w_fade_tick) begin
        r_lvl_r <= w_nxt_r;
        r_lvl_g <= w_nxt_g;
        r_lvl_b <= w_nxt_b;
      end
      if (w_hold_tick)
        r_hold_cnt <= w_hold_done ? '0 : r_hold_cnt + c_hold_w'(1);
      if (w_hold_done)
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      if (w_fade_tick && w_changed) r_valid <= 1'b1;
      else if (iready)              r_valid <= 1'b0;
    end
  end

  assign ovalid = r_valid;
  assign ovidx  = r_idx;

`ifdef RGB_FADE_GAMMA_EN
  function automatic logic [7:0] gamma(input logic [7:0] lvl);
    gamma = 8'(({8'd0, lvl} * {8'd0, lvl}) >> 8);
  endfunction

  assign ovduty_r = gamma(r_lvl_r);
  assign ovduty_g = gamma(r_lvl_g);
  assign ovduty_b = gamma(r_lvl_b);
`else
  assign ovduty_r = r_lvl_r;
  assign ovduty_g = r_lvl_g;
  assign ovduty_b = r_lvl_b;
`endif

endmodule
`default_nettype wire

// File: doc/rgb_fade_seq.md
RGB_FADE_SEQ -- requirements
Module: rgb_fade_seq

Interface
REQ-001 Parameter STEP_DIV, default 12000: clock cycles per fade step (minimum 2).
REQ-002 Parameter HOLD_STEPS, default 64: steps to hold at each palette colour (minimum 1).
REQ-003 iclk  in  1  sole clock, rising edge.
REQ-004 irst  in  1  synchronous active-high reset.
REQ-005 ien  in  1  run enable.
REQ-006 iready  in  1  downstream PWM stage can accept a new duty set.
REQ-007 ovalid  out  1  duty set on ovduty_* is new and pending.
REQ-008 ovduty_r / ovduty_g / ovduty_b  out  8 each  per-channel duty for the downstream PWM.
REQ-009 ovidx  out  3  current target palette index.

Function
REQ-010 Fixed palette of 6 entries (R,G,B), indexed 0..5: 0 = (255,0,0); 1 = (255,255,0); 2 = (0,255,0); 3 = (0,255,255); 4 = (0,0,255); 5 = (255,0,255).
REQ-011 Prescaler: counts 0..STEP_DIV-1 while ien=1 and the FSM is not stalled; a step tick fires when count = STEP_DIV-1, then the count wraps to 0.
REQ-012 FSM states and transitions:
- IDLE -> FADE on the first cycle with ien=1.
- FADE -> HOLD on the step where all three levels equal the target.
- HOLD -> FADE after HOLD_STEPS ticks, with ovidx advanced.
REQ-013 FADE step: each 8-bit channel level moves exactly 1 toward its target and stops at the target, with no overshoot, underflow or overflow.
REQ-014 ovidx advance: 0..4 -> +1; 5 -> 0.
REQ-015 Every tick that changes any level registers the new ovduty_* and sets ovalid=1 on the same edge; HOLD ticks do not assert ovalid.
REQ-016 Handshake: a transfer occurs on a rising edge with ovalid=1 and iready=1; ovalid then clears unless a new update is issued on that same edge.
REQ-017 While ovalid=1 and iready=0, ovduty_* stay stable.
REQ-018 While ovalid=1 and iready=0, the prescaler freezes at STEP_DIV-1, so no update is lost or overwritten.
REQ-019 After the handshake completes, the stalled tick fires on the next edge.
REQ-020 ien=0:
- prescaler, FSM, levels and ovidx are frozen;
- a pending ovalid still completes its handshake;
- on re-enable, operation resumes from the frozen counter value.
REQ-021 If ien falls on the same edge as a tick, the tick is suppressed.
REQ-022 Simultaneous tick and reset: reset wins.

Reset
REQ-023 On irst=1 at a rising edge:
- state=IDLE, prescaler=0, hold counter=0;
- levels=(0,0,0), ovduty_*=0, ovidx=0, ovalid=0.
REQ-024 Reset takes effect from any state, including mid-fade and mid-handshake; the pending transfer is discarded.

Configuration
REQ-025 Macro RGB_FADE_GAMMA_EN, when defined, outputs ovduty_x = (level_x * level_x) >> 8 for each channel.
REQ-026 With RGB_FADE_GAMMA_EN defined, the gamma value is derived from the registered level with no added latency.
REQ-027 With RGB_FADE_GAMMA_EN undefined, ovduty_x = level_x.
REQ-028 FSM, timing and handshake behaviour are identical whether or not RGB_FADE_GAMMA_EN is defined.

Verification
All scenarios run with STEP_DIV=4 and HOLD_STEPS=2 unless stated otherwise.
REQ-029 Reset: hold irst=1 for 3 cycles with ien=1 -> all outputs 0, ovalid=0, ovidx=0.
REQ-030 Fade to red: iready=1, ien=1 -> ovduty_r increments by 1 every 4 cycles while G=B=0.
REQ-031 Hold and advance: once R=255 (255 ovalid pulses), no ovalid for 2 ticks, then ovidx=1 and G starts incrementing.
REQ-032 Backpressure: iready=0 for 20 cycles while ovalid=1 -> ovduty_* unchanged and no level advance. Raise iready -> transfer accepted, next update ovalid one cycle later, then every 4 cycles.
REQ-033 Wrap: from ovidx=5 at (255,0,255) -> ovidx=0; B decrements 255->0 over 255 steps while R stays at 255.
REQ-034 Mid-fade events:
- irst while R=100 -> next cycle all outputs 0 and IDLE.
- ien=0 for 10 cycles at R=50 -> R stays at 50 with no ovalid.
REQ-035 RGB_FADE_GAMMA_EN defined: level 128 -> ovduty 64; level 255 -> ovduty 254; level 1 -> ovduty 0.
